// File: rtl/conv1d_pkg.sv
// Shared definitions for the 1-D convolution engine: FSM state encodings
// and the sizing helpers used by the engine and its testbench.
package conv1d_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOAD_F = 3'd1;
  localparam state_t ST_LOAD_K = 3'd2;
  localparam state_t ST_MAC    = 3'd3;
  localparam state_t ST_EMIT   = 3'd4;

  // Full-precision accumulator width: product width, growth over M taps, plus headroom.
  function automatic int acc_width(input int dw, input int m);
    return 2 * dw + $clog2(m) + 1;
  endfunction

  // Number of outputs a job produces; zero for a configuration the engine rejects.
  function automatic int out_count(input int n, input int m, input int stride, input int pad);
    if (stride == 0 || n + 2 * pad < m) return 0;
    return (n + 2 * pad - m) / stride + 1;
  endfunction

endpackage

// File: rtl/conv1d_mac.sv
// Registered signed multiply-accumulate. 'zero' gates the product so padding
// taps still consume a cycle without disturbing the sum.
module conv1d_mac #(
  parameter int DW = 8,
  parameter int AW = 19
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 en,
  input  logic                 zero,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [AW-1:0] acc
);

  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   term;

  always_comb begin
    prod = (2*DW)'(a) * (2*DW)'(b);
    term = zero ? '0 : {{(AW-2*DW){prod[2*DW-1]}}, prod};
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + term;
    end
  end

endmodule

// File: rtl/conv1d_engine.sv
// 1-D convolution engine: streams in a feature vector and filter, then emits
// zero-padded, strided dot products one MAC per tap per cycle.
module conv1d_engine
  import conv1d_pkg::*;
#(
  parameter int DW = 8,
  parameter int N  = 8,
  parameter int M  = 3,
  parameter int SW = 4,
  parameter int AW = acc_width(DW, M)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [SW-1:0]        stride,
  input  logic [SW-1:0]        pad,
  input  logic                 feat_valid,
  input  logic signed [DW-1:0] feat_data,
  output logic                 feat_ready,
  input  logic                 filt_valid,
  input  logic signed [DW-1:0] filt_data,
  output logic                 filt_ready,
  output logic                 out_valid,
  output logic signed [AW-1:0] out_data,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic                 err
);

  localparam int FAW = (N > 1) ? $clog2(N) : 1;
  localparam int KAW = (M > 1) ? $clog2(M) : 1;
  // Output index must cover the longest padded job: N + 2*(2^SW-1) positions.
  localparam int OW  = $clog2(N + 2 ** (SW + 1) + 1);
  localparam int IW  = OW + SW + 2;

  state_t              state;
  logic [FAW-1:0]      load_cnt;
  logic [KAW-1:0]      k_r;
  logic [OW-1:0]       o_r;
  logic [SW-1:0]       stride_r;
  logic [SW-1:0]       pad_r;

  logic signed [DW-1:0] feat_mem [N];
  logic signed [DW-1:0] filt_mem [M];

  logic [IW-1:0]        idx;
  logic                 in_range;
  logic [IW-1:0]        next_start;
  logic [IW-1:0]        last_start;
  logic                 is_last;
  logic                 cfg_bad;
  logic                 feat_last;
  logic                 filt_last;
  logic                 mac_clear;
  logic signed [DW-1:0] feat_sel;
  logic signed [DW-1:0] filt_sel;
  logic signed [AW-1:0] acc;

  // Index arithmetic is done wide and unsigned; the MSB doubles as the sign of i.
  always_comb begin
    idx        = IW'(o_r) * IW'(stride_r) + IW'(k_r) - IW'(pad_r);
    in_range   = !idx[IW-1] && (idx < IW'(N));
    next_start = (IW'(o_r) + IW'(1)) * IW'(stride_r);
    last_start = IW'(N - M) + (IW'(pad_r) << 1);
    is_last    = next_start > last_start;
    cfg_bad    = (stride == '0) || ((IW'(N) + (IW'(pad) << 1)) < IW'(M));
    feat_last  = (load_cnt == FAW'(N - 1));
    filt_last  = (load_cnt == FAW'(M - 1));
    feat_sel   = feat_mem[idx[FAW-1:0]];
    filt_sel   = filt_mem[k_r];
  end

  always_comb begin
    feat_ready = (state == ST_LOAD_F);
    filt_ready = (state == ST_LOAD_K);
    out_valid  = (state == ST_EMIT);
    out_last   = (state == ST_EMIT) && is_last;
    out_data   = acc;
    busy       = (state != ST_IDLE);
    mac_clear  = (state == ST_LOAD_K && filt_valid && filt_last) ||
                 (state == ST_EMIT && out_ready && !is_last);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      load_cnt <= '0;
      k_r      <= '0;
      o_r      <= '0;
      stride_r <= '0;
      pad_r    <= '0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              err <= 1'b1;
            end else begin
              stride_r <= stride;
              pad_r    <= pad;
              load_cnt <= '0;
              state    <= ST_LOAD_F;
            end
          end
        end
        ST_LOAD_F: begin
          if (feat_valid) begin
            if (feat_last) begin
              load_cnt <= '0;
              state    <= ST_LOAD_K;
            end else begin
              load_cnt <= load_cnt + FAW'(1);
            end
          end
        end
        ST_LOAD_K: begin
          if (filt_valid) begin
            if (filt_last) begin
              load_cnt <= '0;
              o_r      <= '0;
              k_r      <= '0;
              state    <= ST_MAC;
            end else begin
              load_cnt <= load_cnt + FAW'(1);
            end
          end
        end
        ST_MAC: begin
          if (k_r == KAW'(M - 1)) begin
            state <= ST_EMIT;
          end else begin
            k_r <= k_r + KAW'(1);
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            if (is_last) begin
              state <= ST_IDLE;
            end else begin
              o_r   <= o_r + OW'(1);
              k_r   <= '0;
              state <= ST_MAC;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sample buffers are deliberately left out of reset; every job reloads them.
  always_ff @(posedge clk) begin
    if (state == ST_LOAD_F && feat_valid) begin
      feat_mem[load_cnt] <= feat_data;
    end
    if (state == ST_LOAD_K && filt_valid) begin
      filt_mem[load_cnt[KAW-1:0]] <= filt_data;
    end
  end

  conv1d_mac #(
    .DW(DW),
    .AW(AW)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .clear(mac_clear),
    .en   (state == ST_MAC),
    .zero (!in_range),
    .a    (feat_sel),
    .b    (filt_sel),
    .acc  (acc)
  );

endmodule

// File: tb/tb_conv1d_engine.sv
// Directed, table-driven bench for conv1d_engine with hand-computed results
// plus sequences for stalls, config errors and mid-job reset.
module tb_conv1d_engine;

  localparam int DW = 8;
  localparam int N  = 8;
  localparam int M  = 3;
  localparam int SW = 4;
  localparam int AW = 19;
  localparam int TMO = 100;

  typedef struct packed {
    logic [SW-1:0]          stride;
    logic [SW-1:0]          pad;
    logic [N-1:0][DW-1:0]   feat;
    logic [M-1:0][DW-1:0]   filt;
    logic [4:0]             n_out;
    logic [15:0][AW-1:0]    exp;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [SW-1:0]        stride;
  logic [SW-1:0]        pad;
  logic                 feat_valid;
  logic signed [DW-1:0] feat_data;
  logic                 feat_ready;
  logic                 filt_valid;
  logic signed [DW-1:0] filt_data;
  logic                 filt_ready;
  logic                 out_valid;
  logic signed [AW-1:0] out_data;
  logic                 out_ready;
  logic                 out_last;
  logic                 busy;
  logic                 err;

  int n_vec  = 0;
  int n_miss = 0;
  vec_t vecs [5];

  always #5 clk = ~clk;

  conv1d_engine #(.DW(DW), .N(N), .M(M), .SW(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .stride(stride), .pad(pad),
    .feat_valid(feat_valid), .feat_data(feat_data), .feat_ready(feat_ready),
    .filt_valid(filt_valid), .filt_data(filt_data), .filt_ready(filt_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .err(err)
  );

  task automatic checkOutput(input string name, input logic signed [AW-1:0] act,
                             input logic signed [AW-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v, input bit gaps);
    int t;
    start = 1'b1; stride = v.stride; pad = v.pad;
    tick();
    start = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (gaps && (j % 3 == 1)) begin
        feat_valid = 1'b0;
        tick();
      end
      feat_valid = 1'b1; feat_data = v.feat[j];
      t = 0;
      while (!feat_ready && t < TMO) begin tick(); t++; end
      if (!feat_ready) checkOutput("feat_ready_timeout", 0, 1);
      tick();
    end
    feat_valid = 1'b0;
    for (int j = 0; j < M; j++) begin
      if (gaps && j == 1) begin
        filt_valid = 1'b0;
        tick();
      end
      filt_valid = 1'b1; filt_data = v.filt[j];
      t = 0;
      while (!filt_ready && t < TMO) begin tick(); t++; end
      if (!filt_ready) checkOutput("filt_ready_timeout", 0, 1);
      tick();
    end
    filt_valid = 1'b0;
  endtask

  // Collects all outputs of a job; stall_idx selects which output is back-pressured.
  task automatic collectOutputs(input vec_t v, input int stall_idx);
    int t;
    for (int o = 0; o < int'(v.n_out); o++) begin
      t = 0;
      while (!out_valid && t < TMO) begin tick(); t++; end
      if (!out_valid) begin
        checkOutput("out_valid_timeout", 0, 1);
        return;
      end
      if (o == stall_idx) begin
        for (int s = 0; s < 5; s++) begin
          start = (s == 0); stride = '0;
          checkOutput("stall_valid", AW'(out_valid), 1);
          checkOutput("stall_data", out_data, $signed(v.exp[o]));
          tick();
          start = 1'b0;
          checkOutput("err_while_busy", AW'(err), 0);
        end
      end
      checkOutput($sformatf("out_data[%0d]", o), out_data, $signed(v.exp[o]));
      checkOutput($sformatf("out_last[%0d]", o), AW'(out_last),
                  AW'(o == int'(v.n_out) - 1));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    checkOutput("busy_after_job", AW'(busy), 0);
    checkOutput("valid_after_job", AW'(out_valid), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stride = '0; pad = '0;
    feat_valid = 1'b0; feat_data = '0; filt_valid = 1'b0; filt_data = '0;
    out_ready = 1'b0;

    for (int v = 0; v < 5; v++) vecs[v] = '0;
    // feat 1..8, filt {1,0,-1}: each output is f[i]-f[i+2]
    for (int v = 0; v < 3; v++) begin
      for (int j = 0; j < N; j++) vecs[v].feat[j] = DW'(j + 1);
      vecs[v].filt[0] = 8'sd1; vecs[v].filt[1] = 8'sd0; vecs[v].filt[2] = -8'sd1;
    end
    vecs[0].stride = 4'd1; vecs[0].pad = 4'd0; vecs[0].n_out = 5'd6;
    for (int o = 0; o < 6; o++) vecs[0].exp[o] = -AW'(2);
    vecs[1].stride = 4'd1; vecs[1].pad = 4'd1; vecs[1].n_out = 5'd8;
    for (int o = 0; o < 7; o++) vecs[1].exp[o] = -AW'(2);
    vecs[1].exp[7] = AW'(7);
    vecs[2].stride = 4'd2; vecs[2].pad = 4'd0; vecs[2].n_out = 5'd3;
    for (int o = 0; o < 3; o++) vecs[2].exp[o] = -AW'(2);
    // Extreme negative operands: 3 * 16384
    vecs[3].stride = 4'd1; vecs[3].pad = 4'd0; vecs[3].n_out = 5'd6;
    for (int j = 0; j < N; j++) vecs[3].feat[j] = 8'h80;
    for (int j = 0; j < M; j++) vecs[3].filt[j] = 8'h80;
    for (int o = 0; o < 6; o++) vecs[3].exp[o] = AW'(49152);
    // filt {1,2,3}, stride 3, pad 2: padding at both ends
    vecs[4].stride = 4'd3; vecs[4].pad = 4'd2; vecs[4].n_out = 5'd4;
    for (int j = 0; j < N; j++) vecs[4].feat[j] = DW'(j + 1);
    vecs[4].filt[0] = 8'sd1; vecs[4].filt[1] = 8'sd2; vecs[4].filt[2] = 8'sd3;
    vecs[4].exp[0] = AW'(3);  vecs[4].exp[1] = AW'(20);
    vecs[4].exp[2] = AW'(38); vecs[4].exp[3] = AW'(8);

    tick(); tick();
    rst = 1'b0;
    checkOutput("rst_busy", AW'(busy), 0);
    checkOutput("rst_out_valid", AW'(out_valid), 0);
    checkOutput("rst_out_last", AW'(out_last), 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_err", AW'(err), 0);
    checkOutput("rst_feat_ready", AW'(feat_ready), 0);
    checkOutput("rst_filt_ready", AW'(filt_ready), 0);

    for (int v = 0; v < 5; v++) begin
      $display("[TB] job %0d stride=%0d pad=%0d", v, vecs[v].stride, vecs[v].pad);
      applyStimulus(vecs[v], v == 4);
      collectOutputs(vecs[v], -1);
    end

    $display("[TB] back-pressure on output 2");
    applyStimulus(vecs[0], 1'b0);
    collectOutputs(vecs[0], 2);

    $display("[TB] stride=0 rejected");
    start = 1'b1; stride = '0; pad = '0;
    tick();
    start = 1'b0;
    checkOutput("err_pulse", AW'(err), 1);
    checkOutput("err_busy", AW'(busy), 0);
    tick();
    checkOutput("err_one_cycle", AW'(err), 0);
    checkOutput("err_busy_after", AW'(busy), 0);

    $display("[TB] reset during MAC");
    applyStimulus(vecs[0], 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_busy", AW'(busy), 0);
    checkOutput("midrst_out_valid", AW'(out_valid), 0);
    checkOutput("midrst_out_data", out_data, 0);
    applyStimulus(vecs[2], 1'b0);
    collectOutputs(vecs[2], -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
